simmem_resp_bank: RTL and testbench

Response bank that sits directly downstream of the simulated-memory releaser. It stores one direction's responses (read data or write responses) as they come back from the real memory. A response is presented to the requester only when the releaser's per-ID release enable for that response's AXI ID is high. AXI per-ID ordering is preserved; responses with different IDs may leave in any order. One instance is used per response direction.

---
 rtl/simmem_resp_bank.sv | 147 ++++++++++++++
 tb/tb_simmem_resp_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_resp_bank.sv
// Response bank for one AXI response direction: holds responses from memory and
// releases them per ID when the releaser allows, keeping per-ID order.
module simmem_resp_bank #(
    parameter int DataWidth = 64,
    parameter int IDWidth   = 8,
    parameter int Capacity  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DataWidth-1:0]     in_data_i,
    input  logic [2**IDWidth-1:0]    release_en_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DataWidth-1:0]     out_data_o,
    output logic [$clog2(Capacity+1)-1:0] occupancy_o
);
    localparam int IdxW = $clog2(Capacity);
    localparam int OccW = $clog2(Capacity + 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     lock_idx_q, lock_idx_d;
    logic [Capacity-1:0] valid_q;
    logic [DataWidth-1:0] data_q [Capacity];
    logic [IdxW-1:0]     pred_q [Capacity];
    logic [OccW-1:0]     occ_q;

    logic [IDWidth-1:0]  slot_id [Capacity];
    logic [Capacity-1:0] elig, pred_zero, same_id_push, same_id_pop;
    logic [IdxW-1:0]     sel_idx, free_idx, pop_idx;
    logic                any_elig, push, pop;
    logic [IDWidth-1:0]  in_id, pop_id;
    logic [OccW-1:0]     push_cnt;
    logic [IdxW-1:0]     push_pred;

    assign in_id      = in_data_i[IDWidth-1:0];
    assign pop_id     = data_q[pop_idx][IDWidth-1:0];
    assign in_ready_o = occ_q < OccW'(Capacity);
    assign push       = in_valid_i && in_ready_o;
    assign pop        = out_valid_o && out_ready_i;
    assign occupancy_o = occ_q;

    genvar gi;
    generate
        for (gi = 0; gi < Capacity; gi++) begin : g_slot
            assign slot_id[gi]   = data_q[gi][IDWidth-1:0];
            assign pred_zero[gi] = (pred_q[gi] == '0);
            assign elig[gi]      = valid_q[gi] && pred_zero[gi] && release_en_i[slot_id[gi]];
            // The slot leaving this cycle must not count as an older sibling of the new one.
            assign same_id_push[gi] = valid_q[gi] && (slot_id[gi] == in_id)
                                      && !(pop && (pop_idx == IdxW'(gi)));
            assign same_id_pop[gi]  = pop && valid_q[gi] && (slot_id[gi] == pop_id)
                                      && (pop_idx != IdxW'(gi));
        end
    endgenerate

    always_comb begin
        sel_idx  = '0;
        any_elig = 1'b0;
        free_idx = '0;
        push_cnt = '0;
        for (int i = Capacity - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_idx  = IdxW'(i);
                any_elig = 1'b1;
            end
            if (!valid_q[i]) begin
                free_idx = IdxW'(i);
            end
        end
        for (int i = 0; i < Capacity; i++) begin
            push_cnt = push_cnt + OccW'(same_id_push[i]);
        end
        push_pred = IdxW'(push_cnt);
    end

    always_comb begin
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        pop_idx     = sel_idx;
        case (state_q)
            IDLE: begin
                out_valid_o = any_elig;
                if (any_elig) begin
                    out_data_o = data_q[sel_idx];
                end
                if (any_elig && !out_ready_i) begin
                    state_d    = LOCKED;
                    lock_idx_d = sel_idx;
                end
            end
            LOCKED: begin
                // Valid cannot be withdrawn once presented, whatever release_en_i does.
                out_valid_o = 1'b1;
                out_data_o  = data_q[lock_idx_q];
                pop_idx     = lock_idx_q;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            valid_q    <= '0;
            occ_q      <= '0;
            for (int i = 0; i < Capacity; i++) begin
                pred_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            occ_q      <= occ_q + OccW'(push) - OccW'(pop);
            for (int i = 0; i < Capacity; i++) begin
                if (push && (free_idx == IdxW'(i))) begin
                    valid_q[i] <= 1'b1;
                    pred_q[i]  <= push_pred;
                end else if (pop && (pop_idx == IdxW'(i))) begin
                    valid_q[i] <= 1'b0;
                end else if (same_id_pop[i] && !pred_zero[i]) begin
                    pred_q[i] <= pred_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < Capacity; i++) begin
            if (push && (free_idx == IdxW'(i))) begin
                data_q[i] <= in_data_i;
            end
        end
    end

    // A popped slot must be the only same-ID slot with no older sibling.
    assert property (@(posedge clk_i) disable iff (rst_i) (same_id_pop & pred_zero) == '0);

endmodule

// File: tb/tb_simmem_resp_bank.sv
// Randomized and directed bench for simmem_resp_bank against a slot/age model
// where eligibility is "oldest valid response of its ID, released".
module tb_simmem_resp_bank;
    localparam int DW  = 64;
    localparam int IW  = 8;
    localparam int CAP = 16;
    localparam int NID = 2**IW;

    logic           clk = 1'b0;
    logic           rst_i, in_valid_i, out_ready_i;
    logic [DW-1:0]  in_data_i;
    logic [NID-1:0] release_en_i;
    logic           in_ready_o, out_valid_o;
    logic [DW-1:0]  out_data_o;
    logic [4:0]     occupancy_o;

    always #5 clk = ~clk;

    simmem_resp_bank #(.DataWidth(DW), .IDWidth(IW), .Capacity(CAP)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .release_en_i(release_en_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .occupancy_o(occupancy_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: slots with an arrival sequence number instead of counters.
    bit          m_valid [CAP];
    logic [63:0] m_data  [CAP];
    int          m_seq   [CAP];
    bit          m_locked;
    int          m_lidx;
    int          m_seqctr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NID-1:0] bit_of(input int id);
        logic [NID-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

    function automatic bit m_elig(input int i);
        logic [7:0] id;
        if (!m_valid[i]) return 1'b0;
        id = m_data[i][7:0];
        if (!release_en_i[id]) return 1'b0;
        for (int j = 0; j < CAP; j++) begin
            if (m_valid[j] && j != i && m_data[j][7:0] == id && m_seq[j] < m_seq[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < CAP; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    function automatic void m_out(output bit v, output logic [63:0] d, output int sel);
        v = 1'b0; d = '0; sel = -1;
        if (m_locked) begin
            v = 1'b1; d = m_data[m_lidx]; sel = m_lidx;
        end else begin
            for (int i = 0; i < CAP; i++) begin
                if (sel < 0 && m_elig(i)) begin
                    v = 1'b1; d = m_data[i]; sel = i;
                end
            end
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < CAP; i++) m_valid[i] = 1'b0;
        m_locked = 1'b0;
        m_lidx   = 0;
    endfunction

    task automatic compare_all();
        bit v; logic [63:0] d; int s;
        m_out(v, d, s);
        check_val("out_valid", out_valid_o, v);
        if (v) check_val("out_data", out_data_o, d);
        check_val("in_ready", in_ready_o, m_occ() < CAP);
        check_val("occupancy", occupancy_o, m_occ());
    endtask

    task automatic drive(input bit iv, input logic [7:0] id, input logic [55:0] pl,
                         input bit rdy, input logic [NID-1:0] rel);
        @(negedge clk);
        in_valid_i   = iv;
        in_data_i    = {pl, id};
        out_ready_i  = rdy;
        release_en_i = rel;
        #1;
        compare_all();
    endtask

    task automatic tick();
        bit v; logic [63:0] d; int sel, free; bit push, pop;
        @(posedge clk);
        if (rst_i) begin
            m_reset();
            return;
        end
        m_out(v, d, sel);
        pop  = v && out_ready_i;
        push = in_valid_i && (m_occ() < CAP);
        free = -1;
        for (int i = 0; i < CAP; i++) if (!m_valid[i] && free < 0) free = i;
        if (!m_locked && v && !out_ready_i) begin
            m_locked = 1'b1;
            m_lidx   = sel;
        end else if (m_locked && out_ready_i) begin
            m_locked = 1'b0;
        end
        if (pop) m_valid[sel] = 1'b0;
        if (push) begin
            m_valid[free] = 1'b1;
            m_data[free]  = in_data_i;
            m_seq[free]   = m_seqctr++;
        end
        if (push || pop)
            $display("t=%0t push=%0b in=0x%0h pop=%0b out=0x%0h", $time, push, in_data_i, pop, d);
    endtask

    task automatic cycle(input bit iv, input logic [7:0] id, input logic [55:0] pl,
                         input bit rdy, input logic [NID-1:0] rel);
        drive(iv, id, pl, rdy, rel);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        tick();
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [NID-1:0] rel;
        rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0; release_en_i = '0;
        m_reset();
        m_seqctr = 0;
        do_reset();
        drive(0, 0, 0, 1, '0);
        check_val("rst_out_data", out_data_o, 64'h0);
        check_val("rst_occ", occupancy_o, 0);
        tick();

        // Single response held until released
        cycle(1, 3, 56'hA3, 1, '0);
        repeat (5) cycle(0, 0, 0, 1, '0);
        drive(0, 0, 0, 1, bit_of(3));
        check_val("single_valid", out_valid_o, 1);
        check_val("single_data", out_data_o, 64'hA303);
        check_val("single_occ", occupancy_o, 1);
        tick();
        drive(0, 0, 0, 1, '0);
        check_val("single_occ_after", occupancy_o, 0);
        tick();

        // Per-ID ordering
        cycle(1, 5, 56'h1, 1, '0);
        cycle(1, 5, 56'h2, 1, '0);
        drive(0, 0, 0, 1, '1);
        check_val("order_first", out_data_o, 64'h105);
        tick();
        drive(0, 0, 0, 1, '1);
        check_val("order_second", out_data_o, 64'h205);
        tick();

        // Cross-ID reordering
        cycle(1, 1, 56'h11, 1, '0);
        cycle(1, 2, 56'h22, 1, '0);
        drive(0, 0, 0, 1, bit_of(2));
        check_val("xid_first", out_data_o, 64'h2202);
        tick();
        drive(0, 0, 0, 1, bit_of(1));
        check_val("xid_second", out_data_o, 64'h1101);
        tick();

        // Lock under backpressure, then enable dropped
        cycle(1, 4, 56'h44, 0, '0);
        cycle(0, 0, 0, 0, bit_of(4));
        drive(0, 0, 0, 0, '0);
        check_val("lock_valid", out_valid_o, 1);
        check_val("lock_data", out_data_o, 64'h4404);
        tick();
        drive(0, 0, 0, 1, '0);
        check_val("lock_pop_data", out_data_o, 64'h4404);
        tick();
        cycle(0, 0, 0, 1, '0);

        // Full
        for (int i = 0; i < CAP; i++) cycle(1, 8'(16 + i), 56'(i), 1, '0);
        drive(1, 40, 56'hEE, 1, '0);
        check_val("full_ready", in_ready_o, 0);
        check_val("full_occ", occupancy_o, 16);
        tick();
        cycle(0, 0, 0, 1, bit_of(16));
        drive(0, 0, 0, 1, '0);
        check_val("full_ready_after_pop", in_ready_o, 1);
        tick();
        cycle(1, 41, 56'hEF, 1, '0);
        drive(0, 0, 0, 1, '0);
        check_val("full_refill_occ", occupancy_o, 16);
        tick();
        repeat (CAP + 2) cycle(0, 0, 0, 1, '1);

        // Simultaneous push and pop of the same ID
        cycle(1, 7, 56'hA, 1, '0);
        cycle(1, 7, 56'hB, 1, '0);
        drive(1, 7, 56'hC, 1, bit_of(7));
        check_val("simul_first", out_data_o, 64'hA07);
        tick();
        drive(0, 0, 0, 1, bit_of(7));
        check_val("simul_second", out_data_o, 64'hB07);
        tick();
        drive(0, 0, 0, 1, bit_of(7));
        check_val("simul_third", out_data_o, 64'hC07);
        tick();

        // Reset while LOCKED with three slots valid
        cycle(1, 9, 56'h1, 0, '0);
        cycle(1, 10, 56'h2, 0, '0);
        cycle(1, 11, 56'h3, 0, '0);
        cycle(0, 0, 0, 0, bit_of(9));
        do_reset();
        drive(0, 0, 0, 1, '1);
        check_val("rst_mid_occ", occupancy_o, 0);
        check_val("rst_mid_valid", out_valid_o, 0);
        tick();

        // Randomized traffic over a handful of IDs
        rel = '1;
        for (int n = 0; n < 4000; n++) begin
            if (n % 16 == 0) begin
                if ($urandom % 4 == 0) rel = '1;
                else begin
                    rel = '0;
                    for (int id = 0; id < 8; id++) rel[id] = 1'($urandom % 2);
                end
            end
            if ($urandom % 800 == 0) do_reset();
            else cycle(1'($urandom % 3 != 0), 8'($urandom_range(0, 7)), 56'($urandom),
                       1'($urandom % 4 != 0), rel);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
